multi_port_register_file: RTL and testbench

MULTI_PORT_REGISTER_FILE -- requirements
Module: multi_port_register_file

---
 rtl/multi_port_register_file.sv | 176 +++++++++++++++++
 tb/tb_multi_port_register_file.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_register_file.sv
// ---------------------------------------------------------------------------
// multi_port_register_file
//
// Purpose:
//    Register file with one byte-maskable write port and ReadPorts independent
//    read ports. Reads can be combinational or registered, and same-cycle write
//    forwarding is optional. Address 0 can be hard-wired to zero. A Clear pulse
//    starts a sequential wipe that zeroes one register per cycle while Busy is
//    high.
//
// Ports:
//    Clock         rising-edge clock for all state
//    nReset        synchronous, active-low reset
//    WriteEnable   write strobe for the current cycle
//    WriteAddress  write target
//    WriteData     write value
//    ByteEnable    per-byte write mask, bit i covers bits [8i+7:8i]
//    ReadAddress   read port p address in slice p
//    ReadData      read port p data in slice p
//    Clear         single-cycle request to start clearing the whole file
//    Busy          high while a clear sequence is running
// ---------------------------------------------------------------------------
module multi_port_register_file #(
   parameter int AddressWidth   = 6,
   parameter int RegisterHeight = 1 << AddressWidth,
   parameter int RegisterWidth  = 16,
   parameter int ReadPorts      = 2,
   parameter int ReadLatency    = 0,
   parameter int Bypass         = 1,
   parameter int ZeroRegister   = 0
) (
   input  logic                               Clock,
   input  logic                               nReset,
   input  logic                               WriteEnable,
   input  logic [AddressWidth-1:0]            WriteAddress,
   input  logic [RegisterWidth-1:0]           WriteData,
   input  logic [RegisterWidth/8-1:0]         ByteEnable,
   input  logic [ReadPorts*AddressWidth-1:0]  ReadAddress,
   output logic [ReadPorts*RegisterWidth-1:0] ReadData,
   input  logic                               Clear,
   output logic                               Busy
);

   localparam int NumBytes = RegisterWidth / 8;
   // One extra bit so the comparison also works when RegisterHeight == 2^AddressWidth.
   localparam logic [AddressWidth:0]   HeightLimit = (AddressWidth + 1)'(RegisterHeight);
   localparam logic [AddressWidth-1:0] LastIndex   = AddressWidth'(RegisterHeight - 1);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t                            state_q, state_d;
   logic [AddressWidth-1:0]           counter_q, counter_d;
   logic [RegisterWidth-1:0]          mem_q [RegisterHeight];
   logic [RegisterWidth-1:0]          mem_d [RegisterHeight];
   logic                              write_active;
   logic [RegisterWidth-1:0]          write_merged;
   logic [ReadPorts*RegisterWidth-1:0] read_d;

   function automatic logic in_range(input logic [AddressWidth-1:0] addr);
      return {1'b0, addr} < HeightLimit;
   endfunction

   // Addresses past the end of the file hold no storage and read as zero.
   function automatic logic [RegisterWidth-1:0] stored_word(input logic [AddressWidth-1:0] addr);
      logic [RegisterWidth-1:0] word;
      word = '0;
      if (in_range(addr)) begin
         word = mem_q[addr];
      end
      return word;
   endfunction

   // Writes are only accepted while idle, in range, and not aimed at a
   // hard-wired zero register. The merged word keeps disabled bytes intact.
   always_comb begin
      write_active = WriteEnable && (state_q == IDLE) && in_range(WriteAddress)
                     && !((ZeroRegister != 0) && (WriteAddress == '0));
      write_merged = stored_word(WriteAddress);
      for (int b = 0; b < NumBytes; b++) begin
         if (ByteEnable[b]) begin
            write_merged[8*b +: 8] = WriteData[8*b +: 8];
         end
      end
   end

   // Next-state logic: apply an accepted write, then step the clear sequence.
   // A write is never accepted in CLEAR, so the two never target the array
   // in the same cycle.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      mem_d     = mem_q;
      if (write_active) begin
         mem_d[WriteAddress] = write_merged;
      end
      case (state_q)
         IDLE: begin
            if (Clear) begin
               state_d   = CLEAR;
               counter_d = '0;
            end
         end
         CLEAR: begin
            mem_d[counter_q] = '0;
            if (counter_q == LastIndex) begin
               state_d   = IDLE;
               counter_d = '0;
            end else begin
               counter_d = counter_q + AddressWidth'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            counter_d = '0;
         end
      endcase
   end

   // Register array, FSM state and clear counter.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q   <= IDLE;
         counter_q <= '0;
         for (int i = 0; i < RegisterHeight; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         mem_q     <= mem_d;
      end
   end

   assign Busy = (state_q == CLEAR);

   // Per-port read value. Bypass only applies to accepted writes, so it is
   // automatically off during CLEAR and for blocked or out-of-range targets.
   always_comb begin
      read_d = '0;
      for (int p = 0; p < ReadPorts; p++) begin
         if ((ZeroRegister != 0) && (ReadAddress[p*AddressWidth +: AddressWidth] == '0)) begin
            read_d[p*RegisterWidth +: RegisterWidth] = '0;
         end else if ((Bypass != 0) && write_active
                      && (ReadAddress[p*AddressWidth +: AddressWidth] == WriteAddress)) begin
            read_d[p*RegisterWidth +: RegisterWidth] = write_merged;
         end else begin
            read_d[p*RegisterWidth +: RegisterWidth] =
               stored_word(ReadAddress[p*AddressWidth +: AddressWidth]);
         end
      end
   end

   generate
      if (ReadLatency == 1) begin : g_registered_read
         logic [ReadPorts*RegisterWidth-1:0] read_q;

         // Registered read: captures this cycle's read value, which already
         // carries the post-write word when forwarding is enabled.
         always_ff @(posedge Clock) begin
            if (!nReset) begin
               read_q <= '0;
            end else begin
               read_q <= read_d;
            end
         end

         assign ReadData = read_q;
      end else begin : g_comb_read
         assign ReadData = read_d;
      end
   endgenerate

endmodule

// File: tb/tb_multi_port_register_file.sv
// ---------------------------------------------------------------------------
// tb_multi_port_register_file
//
// Drives three register files from one shared stimulus stream:
//    dutA  defaults (combinational read, bypass on)
//    dutB  ReadLatency=1, Bypass=0
//    dutC  RegisterHeight=48, ZeroRegister=1 (combinational read, bypass on)
// A behavioural model of each configuration is compared against every output
// on every negative clock edge, and directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_multi_port_register_file;

   localparam int NumDuts = 3;

   logic        Clock = 1'b0;
   logic        nReset;
   logic        WriteEnable;
   logic [5:0]  WriteAddress;
   logic [15:0] WriteData;
   logic [1:0]  ByteEnable;
   logic [11:0] ReadAddress;
   logic        Clear;

   logic [31:0] readDataA, readDataB, readDataC;
   logic        busyA, busyB, busyC;

   int checks = 0;
   int errors = 0;
   bit checkEnable = 1'b0;

   // Model state, one slot per DUT configuration.
   int          modelMem  [NumDuts][64];
   bit          modelBusy [NumDuts];
   int          modelIdx  [NumDuts];
   logic [15:0] modelRdq  [NumDuts][2];

   always #5 Clock = ~Clock;

   multi_port_register_file dutA (
      .Clock(Clock), .nReset(nReset), .WriteEnable(WriteEnable),
      .WriteAddress(WriteAddress), .WriteData(WriteData), .ByteEnable(ByteEnable),
      .ReadAddress(ReadAddress), .ReadData(readDataA), .Clear(Clear), .Busy(busyA));

   multi_port_register_file #(.ReadLatency(1), .Bypass(0)) dutB (
      .Clock(Clock), .nReset(nReset), .WriteEnable(WriteEnable),
      .WriteAddress(WriteAddress), .WriteData(WriteData), .ByteEnable(ByteEnable),
      .ReadAddress(ReadAddress), .ReadData(readDataB), .Clear(Clear), .Busy(busyB));

   multi_port_register_file #(.RegisterHeight(48), .ZeroRegister(1)) dutC (
      .Clock(Clock), .nReset(nReset), .WriteEnable(WriteEnable),
      .WriteAddress(WriteAddress), .WriteData(WriteData), .ByteEnable(ByteEnable),
      .ReadAddress(ReadAddress), .ReadData(readDataC), .Clear(Clear), .Busy(busyC));

   function automatic int heightOf(input int c);
      return (c == 2) ? 48 : 64;
   endfunction

   function automatic bit latencyOf(input int c);
      return c == 1;
   endfunction

   function automatic bit bypassOf(input int c);
      return c != 1;
   endfunction

   function automatic bit zeroOf(input int c);
      return c == 2;
   endfunction

   function automatic int portAddr(input int p);
      return int'(ReadAddress[p*6 +: 6]);
   endfunction

   function automatic logic [15:0] dutRead(input int c, input int p);
      logic [31:0] word;
      case (c)
         0:       word = readDataA;
         1:       word = readDataB;
         default: word = readDataC;
      endcase
      return word[p*16 +: 16];
   endfunction

   function automatic logic dutBusy(input int c);
      case (c)
         0:       return busyA;
         1:       return busyB;
         default: return busyC;
      endcase
   endfunction

   // New word = enabled bytes from the write data, others from the old word.
   function automatic int mergeBytes(input int oldWord, input int newWord, input logic [1:0] be);
      int mask;
      mask = (be[0] ? 32'h00FF : 0) + (be[1] ? 32'hFF00 : 0);
      return (oldWord & ~mask & 32'hFFFF) | (newWord & mask);
   endfunction

   function automatic bit writeHappens(input int c);
      return WriteEnable && !modelBusy[c] && (int'(WriteAddress) < heightOf(c))
             && !(zeroOf(c) && WriteAddress == 6'd0);
   endfunction

   // What a read of address a returns in the current cycle, before the edge.
   function automatic logic [15:0] expectedRead(input int c, input int a);
      if (zeroOf(c) && a == 0) return 16'h0;
      if (a >= heightOf(c)) return 16'h0;
      if (bypassOf(c) && writeHappens(c) && a == int'(WriteAddress))
         return 16'(mergeBytes(modelMem[c][a], int'(WriteData), ByteEnable));
      return 16'(modelMem[c][a]);
   endfunction

   // Model update at every rising edge.
   initial begin
      forever begin
         @(posedge Clock);
         for (int c = 0; c < NumDuts; c++) begin
            if (!nReset) begin
               for (int a = 0; a < 64; a++) modelMem[c][a] = 0;
               modelBusy[c] = 1'b0;
               modelIdx[c]  = 0;
               modelRdq[c][0] = 16'h0;
               modelRdq[c][1] = 16'h0;
            end else begin
               bit wasBusy;
               for (int p = 0; p < 2; p++) modelRdq[c][p] = expectedRead(c, portAddr(p));
               wasBusy = modelBusy[c];
               if (writeHappens(c))
                  modelMem[c][WriteAddress] = mergeBytes(modelMem[c][WriteAddress], int'(WriteData), ByteEnable);
               if (wasBusy) begin
                  modelMem[c][modelIdx[c]] = 0;
                  modelIdx[c]++;
                  if (modelIdx[c] == heightOf(c)) modelBusy[c] = 1'b0;
               end else if (Clear) begin
                  modelBusy[c] = 1'b1;
                  modelIdx[c]  = 0;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   initial begin
      forever begin
         @(negedge Clock);
         if (checkEnable) begin
            for (int c = 0; c < NumDuts; c++) begin
               for (int p = 0; p < 2; p++) begin
                  logic [15:0] expected;
                  expected = latencyOf(c) ? modelRdq[c][p] : expectedRead(c, portAddr(p));
                  checks++;
                  if (dutRead(c, p) !== expected) begin
                     errors++;
                     $display("[TB] FAIL model_read dut%0d port%0d addr=%0d at %0t: got %h expected %h",
                              c, p, portAddr(p), $time, dutRead(c, p), expected);
                  end
               end
               checks++;
               if (dutBusy(c) !== modelBusy[c]) begin
                  errors++;
                  $display("[TB] FAIL model_busy dut%0d at %0t: got %b expected %b",
                           c, $time, dutBusy(c), modelBusy[c]);
               end
            end
         end
      end
   end

   // One cycle: inputs change just after the rising edge, and the task
   // returns just after the falling edge so outputs can be inspected.
   task automatic applyStimulus(input logic we, input logic [5:0] wa, input logic [15:0] wd,
                                input logic [1:0] be, input logic [5:0] ra0, input logic [5:0] ra1,
                                input logic clr, input logic rstn);
      @(posedge Clock);
      #1;
      WriteEnable  = we;
      WriteAddress = wa;
      WriteData    = wd;
      ByteEnable   = be;
      ReadAddress  = {ra1, ra0};
      Clear        = clr;
      nReset       = rstn;
      @(negedge Clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   initial begin
      nReset = 1'b0; WriteEnable = 1'b0; WriteAddress = '0; WriteData = '0;
      ByteEnable = '0; ReadAddress = '0; Clear = 1'b0;
      for (int c = 0; c < NumDuts; c++) begin
         for (int a = 0; a < 64; a++) modelMem[c][a] = 0;
         modelBusy[c] = 1'b0; modelIdx[c] = 0;
         modelRdq[c][0] = 16'h0; modelRdq[c][1] = 16'h0;
      end

      $display("[TB] reset");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkEnable = 1'b1;
      applyStimulus(0, 0, 0, 0, 3, 40, 0, 1);
      checkOutput("reset_busyA", {15'b0, busyA}, 16'h0);
      checkOutput("reset_readA0", readDataA[15:0], 16'h0);
      checkOutput("reset_readB1", readDataB[31:16], 16'h0);

      $display("[TB] full write and read back");
      applyStimulus(1, 12, 16'hABCD, 2'b11, 12, 12, 0, 1);
      checkOutput("bypass_full_p0", readDataA[15:0], 16'hABCD);
      applyStimulus(0, 0, 0, 0, 12, 12, 0, 1);
      checkOutput("readback_p0", readDataA[15:0], 16'hABCD);
      checkOutput("readback_p1", readDataA[31:16], 16'hABCD);

      $display("[TB] byte-masked write");
      applyStimulus(1, 12, 16'h1234, 2'b01, 12, 12, 0, 1);
      checkOutput("bypass_byte_p0", readDataA[15:0], 16'hAB34);
      checkOutput("bypass_byte_p1", readDataA[31:16], 16'hAB34);
      applyStimulus(0, 0, 0, 0, 12, 12, 0, 1);
      checkOutput("byte_readback", readDataA[15:0], 16'hAB34);

      $display("[TB] registered read without bypass");
      applyStimulus(1, 21, 16'h1111, 2'b11, 21, 21, 0, 1);
      applyStimulus(1, 21, 16'h5555, 2'b11, 21, 21, 0, 1);
      checkOutput("lat1_first", readDataB[15:0], 16'h0000);
      applyStimulus(0, 0, 0, 0, 21, 21, 0, 1);
      checkOutput("lat1_old_p0", readDataB[15:0], 16'h1111);
      checkOutput("lat1_old_p1", readDataB[31:16], 16'h1111);
      applyStimulus(0, 0, 0, 0, 21, 21, 0, 1);
      checkOutput("lat1_new", readDataB[15:0], 16'h5555);

      $display("[TB] zero register and out-of-range address");
      applyStimulus(1, 0, 16'hFFFF, 2'b11, 0, 0, 0, 1);
      checkOutput("zero_bypass_p0", readDataC[15:0], 16'h0);
      checkOutput("zero_bypass_p1", readDataC[31:16], 16'h0);
      checkOutput("nozero_bypass", readDataA[15:0], 16'hFFFF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("zero_after_p0", readDataC[15:0], 16'h0);
      checkOutput("zero_after_p1", readDataC[31:16], 16'h0);
      applyStimulus(1, 50, 16'h7777, 2'b11, 50, 50, 0, 1);
      checkOutput("oor_bypass", readDataC[15:0], 16'h0);
      applyStimulus(0, 0, 0, 0, 50, 50, 0, 1);
      checkOutput("oor_read", readDataC[31:16], 16'h0);
      checkOutput("inrange_read", readDataA[15:0], 16'h7777);

      $display("[TB] random traffic");
      for (int n = 0; n < 500; n++) begin
         logic [5:0] wa, ra0, ra1;
         wa  = 6'($urandom);
         ra0 = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom);
         ra1 = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom);
         applyStimulus(1'($urandom), wa, 16'($urandom), 2'($urandom), ra0, ra1,
                       $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
      end

      $display("[TB] fill then clear");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1, 6'(i), 16'h8000 | 16'(i), 2'b11, 6'(i), 63, 0, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 63, 1, 1);
      checkOutput("clear_req_busy", {15'b0, busyA}, 16'h0);
      for (int k = 0; k < 64; k++) begin
         applyStimulus(k == 30, 5, 16'h1234, 2'b11, 0, 63, 0, 1);
         checkOutput("clear_busy", {15'b0, busyA}, 16'h1);
         checkOutput("clear_addr0", readDataA[15:0], (k == 0) ? 16'h8000 : 16'h0000);
         checkOutput("clear_addr63", readDataA[31:16], 16'h803F);
      end
      applyStimulus(0, 0, 0, 0, 5, 63, 0, 1);
      checkOutput("clear_done_busy", {15'b0, busyA}, 16'h0);
      checkOutput("clear_write_lost", readDataA[15:0], 16'h0);
      checkOutput("clear_addr63_done", readDataA[31:16], 16'h0);

      $display("[TB] write with clear, then reset mid-clear");
      applyStimulus(1, 7, 16'h4242, 2'b11, 7, 7, 1, 1);
      checkOutput("wrclr_bypass", readDataA[15:0], 16'h4242);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 0, 0, 0, 7, 7, 0, 1);
         checkOutput("wrclr_busy", {15'b0, busyA}, 16'h1);
         if (k == 0) checkOutput("wrclr_kept", readDataA[15:0], 16'h4242);
      end
      applyStimulus(1, 9, 16'h9999, 2'b11, 9, 9, 1, 0);
      for (int a = 0; a < 32; a++) begin
         applyStimulus(0, 0, 0, 0, 6'(2*a), 6'(2*a + 1), 0, 1);
         checkOutput("abort_busy", {15'b0, busyA}, 16'h0);
         checkOutput("abort_p0", readDataA[15:0], 16'h0);
         checkOutput("abort_p1", readDataA[31:16], 16'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
